readout_sequencer: RTL and testbench
====================================

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4, number of single-channel capture instances sequenced.
REQ-002 SHALL have parameter AW, default 12, read-address width.
REQ-003 SHALL have port sysclk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port arm  in  1  single-cycle request to start one event.
REQ-006 SHALL have port trigger_in  in  1  external trigger level, sampled each cycle.
REQ-007 SHALL have port adc_ready  in  NCH  per-channel ADC-ready flags.
REQ-008 SHALL have port capture_len  in  AW  samples per capture window.
REQ-009 SHALL have port word_num  in  16  words per channel readout; only [AW-1:0] used.
REQ-010 SHALL have port spi_ss  in  1  SPI slave select, active-low.
REQ-011 SHALL have port spi_done  in  1  single-cycle pulse per transferred word.
REQ-012 SHALL have port trig_out  out  1  single-cycle trigger to all channels.
REQ-013 SHALL have port read_request  out  NCH  one-hot; selected channel during readout.
REQ-014 SHALL have port read_address  out  AW  registered buffer read address.
REQ-015 SHALL have port ch_sel  out  $clog2(NCH)  index of channel being read.
REQ-016 SHALL have ports busy  out  1 (not IDLE), evt_done  out  1 (pulse), evt_count  out  16, overrun  out  1 (sticky).

Function
REQ-017 SHALL implement states IDLE, WAIT_RDY, ARMED, CAPTURE, READOUT, DONE.
REQ-018 SHALL move IDLE->WAIT_RDY on arm; WAIT_RDY->ARMED when all adc_ready bits high.
REQ-019 SHALL, in ARMED, detect trigger_in rising edge, pulse trig_out next cycle, enter CAPTURE.
REQ-020 SHALL hold CAPTURE exactly capture_len cycles (capture_len=0 treated as 1), then enter READOUT with ch_sel=0.
REQ-021 SHALL, in READOUT with spi_ss low, increment read_address on spi_done; at spi_done with address=word_num-1, reset address to 0 and advance ch_sel.
REQ-022 SHALL, when spi_ss rises mid-channel, reset read_address to 0 and restart the same channel.
REQ-023 SHALL skip READOUT (go to DONE) when word_num[AW-1:0]=0; word_num beyond 2^AW wraps modulo 2^AW.
REQ-024 SHALL, after last channel's final word, enter DONE, pulse evt_done one cycle, increment evt_count (wraps at 16'hFFFF->0), return to IDLE.
REQ-025 SHALL ignore arm outside IDLE; trigger edge outside ARMED sets overrun.
REQ-026 SHALL drive read_request zero outside READOUT; spi_done outside READOUT is ignored.

Reset
REQ-027 SHALL, on rst (including mid-event), enter IDLE, clear read_address, ch_sel, read_request, trig_out, evt_done, busy, overrun, evt_count, and trigger edge history, next edge.

Configuration
REQ-028 SHALL, with READOUT_HEADER_EN defined, add outputs hdr_sel (1) and hdr_word (16) = {4'hA, ch_sel zero-extended to 4, evt_count[7:0]}; first spi_done per channel consumes the header with address held at 0.
REQ-029 SHALL, without READOUT_HEADER_EN, omit those ports; readout identical to REQ-021.

Structure
REQ-030 SHALL place the state enumeration and header nibble constant 4'hA in shared package digitizer_pkg.
REQ-031 SHALL implement the address/channel counter as sub-module readout_addr_ctr; FSM stays top-level.

Verification
REQ-032 SHALL cover nominal event: NCH=4, capture_len=8, word_num=3, 12 spi_done -> addresses 0,1,2 per channel, evt_done once, evt_count=1.
REQ-033 SHALL cover ready gating: arm with adc_ready=4'b0111 -> stays WAIT_RDY, no trig_out until 4'b1111.
REQ-034 SHALL cover SS abort: spi_ss high after 2 words of ch1 -> read_address=0, ch_sel=1 retained.
REQ-035 SHALL cover overrun: trigger edge during READOUT -> overrun=1, sequencing unaffected; rst clears it.
REQ-036 SHALL cover word_num=0 -> no read_request, evt_done 1 cycle after CAPTURE ends.
REQ-037 SHALL cover header build: READOUT_HEADER_EN, evt_count=5, ch 2 -> hdr_word=16'hA205, then addresses 0..word_num-1.

Source files
------------

// File: rtl/digitizer_pkg.sv
// Shared definitions for the digitizer readout path: sequencer state encoding,
// the readout header marker nibble and the header word builder.
package digitizer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    ARMED,
    CAPTURE,
    READOUT,
    DONE
  } seq_state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Header word layout: marker nibble, channel index, low byte of event count.
  function automatic logic [15:0] hdr_build(input logic [3:0] ch, input logic [7:0] cnt);
    return {HDR_NIBBLE, ch, cnt};
  endfunction

endpackage

// File: rtl/readout_addr_ctr.sv
// Buffer read address / channel index counter for the readout phase.
// Held at zero while inactive; spi_ss high rewinds the current channel.
// Optional header slot per channel when READOUT_HEADER_EN is defined.
module readout_addr_ctr
  import digitizer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 12,
  parameter int CW  = 2
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          active,
  input  logic          spi_ss,
  input  logic          spi_done,
  input  logic [AW-1:0] words,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] ch,
`ifdef READOUT_HEADER_EN
  output logic          hdr_pend,
`endif
  output logic          last
);

  localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);

  logic step, data_step, word_end;

  assign step     = active & ~spi_ss & spi_done;
  assign word_end = (addr == words - 1'b1);

`ifdef READOUT_HEADER_EN
  logic hdr_q;
  assign hdr_pend  = hdr_q;
  assign data_step = step & ~hdr_q;

  // Header pending at the start of every channel and after every rewind.
  always_ff @(posedge sysclk) begin
    if (rst || !active || spi_ss) hdr_q <= 1'b1;
    else if (step)                hdr_q <= ~hdr_q & word_end;
  end
`else
  assign data_step = step;
`endif

  assign last = data_step & word_end & (ch == CH_LAST);

  // Address walks 0..words-1 per channel, then the channel index advances.
  always_ff @(posedge sysclk) begin
    if (rst || !active) begin
      addr <= '0;
      ch   <= '0;
    end else if (spi_ss) begin
      addr <= '0;
    end else if (data_step) begin
      if (word_end) begin
        addr <= '0;
        ch   <= (ch == CH_LAST) ? '0 : ch + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sequencer.sv
// Event sequencer: arm -> wait for ADC ready -> trigger -> fixed capture
// window -> per-channel SPI readout -> event done.
// Optional build macro READOUT_HEADER_EN adds a header word per channel
// (hdr_sel / hdr_word ports).
module readout_sequencer
  import digitizer_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int AW  = 12,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           sysclk,
  input  logic           rst,
  input  logic           arm,
  input  logic           trigger_in,
  input  logic [NCH-1:0] adc_ready,
  input  logic [AW-1:0]  capture_len,
  input  logic [15:0]    word_num,
  input  logic           spi_ss,
  input  logic           spi_done,
  output logic           trig_out,
  output logic [NCH-1:0] read_request,
  output logic [AW-1:0]  read_address,
  output logic [CW-1:0]  ch_sel,
  output logic           busy,
  output logic           evt_done,
  output logic [15:0]    evt_count,
  output logic           overrun
`ifdef READOUT_HEADER_EN
  ,
  output logic           hdr_sel,
  output logic [15:0]    hdr_word
`endif
);

  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  seq_state_t    state, state_nx;
  logic          trig_q, trig_edge, rd_last;
  logic [AW-1:0] cap_cnt, cap_last, words;
  logic          unused_word_num;

  // Upper word_num bits are ignored: the count wraps modulo 2^AW.
  assign words           = word_num[AW-1:0];
  assign unused_word_num = ^word_num;
  assign trig_edge       = trigger_in & ~trig_q;
  assign cap_last        = (capture_len == '0) ? '0 : capture_len - 1'b1;

`ifdef READOUT_HEADER_EN
  logic hdr_pend;
  assign hdr_sel  = (state == READOUT) & hdr_pend;
  assign hdr_word = hdr_build(4'(ch_sel), evt_count[7:0]);
`endif

  readout_addr_ctr #(.NCH(NCH), .AW(AW), .CW(CW)) u_ctr (
    .sysclk   (sysclk),
    .rst      (rst),
    .active   (state == READOUT),
    .spi_ss   (spi_ss),
    .spi_done (spi_done),
    .words    (words),
    .addr     (read_address),
    .ch       (ch_sel),
`ifdef READOUT_HEADER_EN
    .hdr_pend (hdr_pend),
`endif
    .last     (rd_last)
  );

  // State register.
  always_ff @(posedge sysclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nx     = state;
    busy         = (state != IDLE);
    evt_done     = (state == DONE);
    read_request = '0;
    case (state)
      IDLE:     if (arm) state_nx = WAIT_RDY;
      WAIT_RDY: if (&adc_ready) state_nx = ARMED;
      ARMED:    if (trig_edge) state_nx = CAPTURE;
      CAPTURE:  if (cap_cnt == cap_last) state_nx = (words == '0) ? DONE : READOUT;
      READOUT: begin
        read_request = ONE_HOT0 << ch_sel;
        if (rd_last) state_nx = DONE;
      end
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Trigger history, trigger pulse, capture timer, overrun flag, event counter.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      trig_q    <= 1'b0;
      trig_out  <= 1'b0;
      overrun   <= 1'b0;
      cap_cnt   <= '0;
      evt_count <= '0;
    end else begin
      trig_q   <= trigger_in;
      trig_out <= (state == ARMED) && trig_edge;
      if (trig_edge && state != ARMED) overrun <= 1'b1;
      cap_cnt  <= (state == CAPTURE) ? cap_cnt + 1'b1 : '0;
      if (state == DONE) evt_count <= evt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: stimulus pushes expected words,
// event completions and state snapshots; one monitor pops and compares.
module tb_readout_sequencer;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int CW  = 2;
`ifdef READOUT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic           sysclk = 1'b0;
  logic           rst = 1'b1, arm = 1'b0, trigger_in = 1'b0, spi_ss = 1'b1, spi_done = 1'b0;
  logic [NCH-1:0] adc_ready = '0;
  logic [AW-1:0]  capture_len = '0;
  logic [15:0]    word_num = '0;
  logic           trig_out, busy, evt_done, overrun;
  logic [NCH-1:0] read_request;
  logic [AW-1:0]  read_address;
  logic [CW-1:0]  ch_sel;
  logic [15:0]    evt_count;
  logic           got_hdr;
  logic [15:0]    got_hw;

  readout_sequencer #(.NCH(NCH), .AW(AW)) dut (
    .sysclk(sysclk), .rst(rst), .arm(arm), .trigger_in(trigger_in),
    .adc_ready(adc_ready), .capture_len(capture_len), .word_num(word_num),
    .spi_ss(spi_ss), .spi_done(spi_done), .trig_out(trig_out),
    .read_request(read_request), .read_address(read_address), .ch_sel(ch_sel),
    .busy(busy), .evt_done(evt_done), .evt_count(evt_count), .overrun(overrun)
`ifdef READOUT_HEADER_EN
    , .hdr_sel(got_hdr), .hdr_word(got_hw)
`endif
  );

`ifndef READOUT_HEADER_EN
  assign got_hdr = 1'b0;
  assign got_hw  = 16'h0;
`endif

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [CW-1:0] ch;
    logic [AW-1:0] addr;
    logic          hdr;
    logic [15:0]   hw;
  } word_t;

  typedef struct {
    string          name;
    logic           busy, ovr;
    logic [15:0]    cnt;
    logic [AW-1:0]  addr;
    logic [CW-1:0]  ch;
    logic [NCH-1:0] rdreq;
    int             trigs, evts;
  } snap_t;

  word_t       wq[$];
  snap_t       sq[$];
  logic [15:0] eq[$];
  int n_vec = 0, n_err = 0;
  int trig_seen = 0, evt_seen = 0;
  logic probe = 1'b0, tmo = 1'b0, fin = 1'b0;

  // stimulus-side model
  int exp_trigs = 0, exp_evts = 0;
  logic [15:0] exp_cnt = '0;
  logic exp_ovr = 1'b0;

  // Monitor: the only process that compares and steps the counters.
  always @(negedge sysclk) begin : mon
    word_t w;
    snap_t s;
    logic [15:0] e;
    logic [NCH-1:0] oh;
    logic [15:0] hw_got;
    if (trig_out) trig_seen++;
    if (evt_done) begin
      evt_seen++;
      n_vec++;
      if (eq.size() == 0) begin
        n_err++;
        $display("FAIL evt_done: unexpected pulse, evt_count=%0d", evt_count);
      end else begin
        e = eq.pop_front();
        if (evt_count !== e) begin
          n_err++;
          $display("FAIL evt_done: evt_count got %0d want %0d", evt_count, e);
        end
      end
    end
    if (!rst && spi_done && !spi_ss && read_request != '0) begin
      n_vec++;
      if (wq.size() == 0) begin
        n_err++;
        $display("FAIL word: unexpected read ch=%0d addr=%0d", ch_sel, read_address);
      end else begin
        w = wq.pop_front();
        oh = '0;
        oh[w.ch] = 1'b1;
        hw_got = w.hdr ? got_hw : 16'h0;
        if ({ch_sel, read_address, read_request, got_hdr, hw_got} !== {w.ch, w.addr, oh, w.hdr, w.hw}) begin
          n_err++;
          $display("FAIL word: got ch=%0d addr=%0d req=%b hdr=%0b hw=%h, want ch=%0d addr=%0d req=%b hdr=%0b hw=%h",
                   ch_sel, read_address, read_request, got_hdr, hw_got, w.ch, w.addr, oh, w.hdr, w.hw);
        end
      end
    end
    if (probe) begin
      n_vec++;
      if (sq.size() == 0) begin
        n_err++;
        $display("FAIL probe: no expectation queued");
      end else begin
        s = sq.pop_front();
        if ({busy, overrun, evt_count, read_address, ch_sel, read_request} !==
            {s.busy, s.ovr, s.cnt, s.addr, s.ch, s.rdreq} || trig_seen != s.trigs || evt_seen != s.evts) begin
          n_err++;
          $display("FAIL %s: got busy=%0b ovr=%0b cnt=%0d addr=%0d ch=%0d req=%b trigs=%0d evts=%0d, want busy=%0b ovr=%0b cnt=%0d addr=%0d ch=%0d req=%b trigs=%0d evts=%0d",
                   s.name, busy, overrun, evt_count, read_address, ch_sel, read_request, trig_seen, evt_seen,
                   s.busy, s.ovr, s.cnt, s.addr, s.ch, s.rdreq, s.trigs, s.evts);
        end
      end
    end
    if (tmo) begin
      n_vec++;
      n_err++;
      $display("FAIL readout_start: no read_request within cycle budget");
    end
    if (fin) begin
      n_vec++;
      if (wq.size() != 0 || sq.size() != 0 || eq.size() != 0) begin
        n_err++;
        $display("FAIL drain: words=%0d probes=%0d events=%0d still pending, want 0", wq.size(), sq.size(), eq.size());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic snap(input string nm, input logic b, input logic [AW-1:0] a,
                      input logic [CW-1:0] c, input logic [NCH-1:0] rq);
    snap_t s;
    s.name = nm; s.busy = b; s.ovr = exp_ovr; s.cnt = exp_cnt;
    s.addr = a; s.ch = c; s.rdreq = rq; s.trigs = exp_trigs; s.evts = exp_evts;
    sq.push_back(s);
    probe = 1'b1;
    tick();
    probe = 1'b0;
  endtask

  task automatic arm_it();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic fire();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    exp_trigs++;
  endtask

  task automatic pulse_done();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    tick();
  endtask

  task automatic send_ch(input int ch, input int a0, input int a1, input bit hdr);
    word_t w;
    if (hdr && HDR_EN) begin
      w.ch = CW'(ch); w.addr = '0; w.hdr = 1'b1; w.hw = {4'hA, 4'(ch), exp_cnt[7:0]};
      wq.push_back(w);
      pulse_done();
    end
    for (int a = a0; a <= a1; a++) begin
      w.ch = CW'(ch); w.addr = AW'(a); w.hdr = 1'b0; w.hw = 16'h0;
      wq.push_back(w);
      pulse_done();
    end
  endtask

  task automatic wait_readout();
    int k = 0;
    while (read_request == '0 && k < 64) begin
      tick();
      k++;
    end
    if (read_request == '0) begin
      tmo = 1'b1;
      tick();
      tmo = 1'b0;
    end
  endtask

  task automatic full_readout(input int nw);
    spi_ss = 1'b0;
    tick();
    for (int c = 0; c < NCH; c++) send_ch(c, 0, nw - 1, 1'b1);
    exp_cnt++;
    exp_evts++;
    spi_ss = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick();
    snap("reset", 1'b0, '0, '0, '0);

    // nominal event with ready gating, capture_len=8, word_num=3
    capture_len = 12'd8; word_num = 16'd3; adc_ready = 4'b0111;
    arm_it();
    tick(3);
    snap("wait_rdy", 1'b1, '0, '0, '0);
    adc_ready = 4'b1111;
    tick(2);
    eq.push_back(exp_cnt);
    fire();
    snap("trig_pulse", 1'b1, '0, '0, '0);
    tick(6);
    snap("cap8_last", 1'b1, '0, '0, 4'b0000);
    snap("cap8_rd", 1'b1, '0, '0, 4'b0001);
    full_readout(3);
    snap("evt1_done", 1'b0, '0, '0, '0);
    spi_ss = 1'b0;
    pulse_done();
    pulse_done();
    spi_ss = 1'b1;
    snap("idle_spi", 1'b0, '0, '0, '0);

    // capture_len=0 acts as 1; SS abort on ch1; overrun during readout
    capture_len = 12'd0;
    arm_it();
    tick(2);
    eq.push_back(exp_cnt);
    fire();
    snap("cap0_a", 1'b1, '0, '0, 4'b0000);
    snap("cap0_b", 1'b1, '0, '0, 4'b0001);
    spi_ss = 1'b0;
    tick();
    send_ch(0, 0, 2, 1'b1);
    send_ch(1, 0, 1, 1'b1);
    spi_ss = 1'b1;
    arm_it();
    tick();
    snap("ss_abort", 1'b1, '0, 2'd1, 4'b0010);
    spi_ss = 1'b0;
    tick();
    send_ch(1, 0, 2, 1'b1);
    send_ch(2, 0, 0, 1'b1);
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    exp_ovr = 1'b1;
    tick();
    snap("ovr_set", 1'b1, 12'd1, 2'd2, 4'b0100);
    send_ch(2, 1, 2, 1'b0);
    send_ch(3, 0, 2, 1'b1);
    exp_cnt++;
    exp_evts++;
    spi_ss = 1'b1;
    tick(2);
    snap("evt2_done", 1'b0, '0, '0, '0);

    // word_num wraps to 0: readout skipped, DONE right after capture
    capture_len = 12'd2; word_num = 16'h1000;
    arm_it();
    tick(2);
    eq.push_back(exp_cnt);
    fire();
    tick();
    snap("skip_cap", 1'b1, '0, '0, '0);
    exp_evts++;
    snap("skip_done", 1'b1, '0, '0, '0);
    exp_cnt++;
    tick();
    snap("skip_idle", 1'b0, '0, '0, '0);

    // two more skipped events bring evt_count to 5
    capture_len = 12'd1; word_num = 16'd0;
    for (int i = 0; i < 2; i++) begin
      arm_it();
      tick(2);
      eq.push_back(exp_cnt);
      fire();
      tick(4);
      exp_cnt++;
      exp_evts++;
    end

    // evt_count=5; word_num=0x1003 wraps to 3 words; ch2 header is A205
    capture_len = 12'd3; word_num = 16'h1003;
    arm_it();
    tick(2);
    eq.push_back(exp_cnt);
    fire();
    wait_readout();
    full_readout(3);
    snap("evt6_done", 1'b0, '0, '0, '0);

    // reset in the middle of a readout
    capture_len = 12'd1; word_num = 16'd3;
    arm_it();
    tick(2);
    fire();
    wait_readout();
    spi_ss = 1'b0;
    tick();
    send_ch(0, 0, 1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    spi_ss = 1'b1;
    exp_cnt = '0;
    exp_ovr = 1'b0;
    snap("mid_rst", 1'b0, '0, '0, '0);

    tick(2);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
